memory_arbiter: RTL and testbench

Shares the single data memory port of the accelerator between two requesters: the decoder (write-only, port 0) and the external test/host interface (read or write, port 1). One transaction runs at a time. Each requester uses a req/ack handshake. Grants alternate round-robin when both requesters compete. The block sits between the decoder/host and the memory module, and drives the memory's start, rwn, address and data inputs.

---
 rtl/memory_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one data memory port between the decoder (write-only)
// and the host (read/write). One transaction at a time, req/ack handshake per port.
module memory_arbiter #(
    parameter int address_size = 16,
    parameter int data_width   = 32,
    parameter int mem_latency  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dec_req,
    input  logic [address_size-1:0] dec_address,
    input  logic [data_width-1:0]   dec_data,
    output logic                    dec_ack,
    input  logic                    host_req,
    input  logic                    host_rwn,
    input  logic [address_size-1:0] host_address,
    input  logic [data_width-1:0]   host_wdata,
    output logic                    host_ack,
    output logic [data_width-1:0]   host_rdata,
    output logic                    mem_start,
    output logic                    mem_rwn,
    output logic [address_size-1:0] mem_address,
    output logic [data_width-1:0]   mem_data_in,
    input  logic [data_width-1:0]   mem_data_out,
    output logic                    busy,
    output logic                    grant
);

    // state | meaning
    // IDLE  | sample requests, grant one (round-robin on contention)
    // ISSUE | one-cycle mem_start, load latency timer
    // WAIT  | count down memory latency, capture read data on last cycle
    // RESP  | pulse ack of granted port, remember it as last_grant
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] latency_load = 4'(mem_latency);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       last_grant;
    logic       load;
    logic       sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = 1'b0;
        mem_start = 1'b0;
        dec_ack   = 1'b0;
        host_ack  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (dec_req && host_req) begin
                    load = 1'b1;
                    sel  = ~last_grant;
                end else if (dec_req) begin
                    load = 1'b1;
                end else if (host_req) begin
                    load = 1'b1;
                    sel  = 1'b1;
                end
                if (load) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                dec_ack   = ~grant;
                host_ack  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            mem_rwn     <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            host_rdata  <= '0;
            wait_cnt    <= 4'd0;
        end else begin
            // decoder grants are always writes
            if (load) begin
                grant       <= sel;
                mem_rwn     <= sel & host_rwn;
                mem_address <= sel ? host_address : dec_address;
                mem_data_in <= sel ? host_wdata : dec_data;
            end
            case (state)
                ISSUE: wait_cnt <= latency_load;
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    if (wait_cnt <= 4'd1 && mem_rwn) begin
                        host_rdata <= mem_data_out;
                    end
                end
                RESP: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: transaction-level reference model predicts
// grant order, memory contents and read data; a monitor checks each start and ack.
module tb_memory_arbiter;

    typedef struct {
        bit          port;
        bit          rwn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_req = 1'b0, host_req = 1'b0, host_rwn = 1'b0;
    logic [15:0] dec_address = '0, host_address = '0;
    logic [31:0] dec_data = '0, host_wdata = '0;
    logic        dec_ack, host_ack, mem_start, mem_rwn, busy, grant;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in, host_rdata;
    logic [31:0] mem_data_out = '0;

    logic        q_reset = 1'b0, q_host_req = 1'b0, q_host_rwn = 1'b0;
    logic [15:0] q_host_address = '0;
    logic [31:0] q_mem_data_out = '0;
    logic        q_dec_ack, q_host_ack, q_mem_start, q_mem_rwn, q_busy, q_grant;
    logic [15:0] q_mem_address;
    logic [31:0] q_mem_data_in, q_host_rdata;

    memory_arbiter #(.address_size(16), .data_width(32), .mem_latency(1)) dut (
        .clk(clk), .reset(reset),
        .dec_req(dec_req), .dec_address(dec_address), .dec_data(dec_data), .dec_ack(dec_ack),
        .host_req(host_req), .host_rwn(host_rwn), .host_address(host_address),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy), .grant(grant)
    );

    memory_arbiter #(.address_size(16), .data_width(32), .mem_latency(4)) dut4 (
        .clk(clk), .reset(q_reset),
        .dec_req(1'b0), .dec_address(16'h0000), .dec_data(32'h0), .dec_ack(q_dec_ack),
        .host_req(q_host_req), .host_rwn(q_host_rwn), .host_address(q_host_address),
        .host_wdata(32'h0), .host_ack(q_host_ack), .host_rdata(q_host_rdata),
        .mem_start(q_mem_start), .mem_rwn(q_mem_rwn), .mem_address(q_mem_address),
        .mem_data_in(q_mem_data_in), .mem_data_out(q_mem_data_out),
        .busy(q_busy), .grant(q_grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // environment memory: read data is valid only in the cycle after the start strobe
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_start && !mem_rwn) env_mem[mem_address[7:0]] <= mem_data_in;
        if (mem_start && mem_rwn) mem_data_out <= env_mem[mem_address[7:0]];
        else mem_data_out <= $urandom;
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc0 = 0;
    txn_t        exp_mem[$];
    txn_t        exp_ack[$];
    int          start_log[$];
    int          ack_log[$];
    int          grant_log[$];
    logic [31:0] ref_mem [int];
    bit          model_last = 1'b1;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic int log_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_txn(input bit port, input bit rwn, input logic [15:0] addr,
                            input logic [31:0] wd, input bit with_ack);
        txn_t e;
        e.port  = port;
        e.rwn   = port & rwn;
        e.addr  = addr;
        e.wdata = wd;
        if (e.rwn) model_rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 32'h0;
        else ref_mem[int'(addr)] = wd;
        e.rdata = model_rdata;
        model_last = port;
        exp_mem.push_back(e);
        if (with_ack) exp_ack.push_back(e);
    endtask

    task automatic run_round(input bit d_en, input bit h_en, input logic [15:0] da,
                             input logic [31:0] dd, input bit hr, input logic [15:0] ha,
                             input logic [31:0] hw);
        bit pend_d, pend_h;
        int budget;
        if (d_en && h_en) begin
            if (model_last) begin
                push_txn(1'b0, 1'b0, da, dd, 1'b1);
                push_txn(1'b1, hr, ha, hw, 1'b1);
            end else begin
                push_txn(1'b1, hr, ha, hw, 1'b1);
                push_txn(1'b0, 1'b0, da, dd, 1'b1);
            end
        end else if (d_en) begin
            push_txn(1'b0, 1'b0, da, dd, 1'b1);
        end else if (h_en) begin
            push_txn(1'b1, hr, ha, hw, 1'b1);
        end
        dec_req = d_en; dec_address = da; dec_data = dd;
        host_req = h_en; host_rwn = hr; host_address = ha; host_wdata = hw;
        pend_d = d_en;
        pend_h = h_en;
        budget = 0;
        while ((pend_d || pend_h) && budget < 40) begin
            step();
            budget++;
            if (dec_ack) begin pend_d = 1'b0; dec_req = 1'b0; end
            if (host_ack) begin pend_h = 1'b0; host_req = 1'b0; end
        end
        chk("round_timeout", 32'(pend_d | pend_h), 32'h0);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        dec_req = 1'b0;
        host_req = 1'b0;
        model_last = 1'b1;
        model_rdata = '0;
        repeat (2) step();
    endtask

    task automatic rel_reset();
        reset = 1'b1;
        cyc0 = cyc;
        start_log.delete();
        ack_log.delete();
        grant_log.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({mem_start, mem_rwn, dec_ack, host_ack, busy, grant}), 32'h0);
        chk({tag, "_addr"}, 32'(mem_address), 32'h0);
        chk({tag, "_wdata"}, mem_data_in, 32'h0);
        chk({tag, "_rdata"}, host_rdata, 32'h0);
    endtask

    initial begin
        bit   prev_start;
        int   start_rel;
        txn_t e;
        bit   found;
        int   r;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    prev_start = 1'b0;
                end else begin
                    if (mem_start) begin
                        chk("start_spacing", 32'(prev_start), 32'h0);
                        start_rel = cyc - cyc0;
                        start_log.push_back(start_rel);
                        chk("start_expected", 32'(exp_mem.size() != 0), 32'h1);
                        if (exp_mem.size() != 0) begin
                            e = exp_mem.pop_front();
                            chk("start_grant", 32'(grant), 32'(e.port));
                            chk("start_rwn", 32'(mem_rwn), 32'(e.rwn));
                            chk("start_addr", 32'(mem_address), 32'(e.addr));
                            if (!e.rwn) chk("start_wdata", mem_data_in, e.wdata);
                        end
                    end
                    if (dec_ack || host_ack) begin
                        ack_log.push_back(cyc - cyc0);
                        grant_log.push_back(int'(host_ack));
                        chk("ack_exclusive", 32'(dec_ack & host_ack), 32'h0);
                        chk("ack_latency", 32'(cyc - cyc0 - start_rel), 32'd2);
                        chk("ack_expected", 32'(exp_ack.size() != 0), 32'h1);
                        if (exp_ack.size() != 0) begin
                            e = exp_ack.pop_front();
                            chk("ack_port", 32'(host_ack), 32'(e.port));
                            if (host_ack) chk("ack_rdata", host_rdata, e.rdata);
                        end
                    end
                    prev_start = mem_start;
                end
            end
        join_none

        do_reset();
        chk_zero("reset");

        rel_reset();
        run_round(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 16'h0, 32'h0);
        chk("A_start_cycle", 32'(log_at(start_log, 0)), 32'd1);
        chk("A_ack_cycle", 32'(log_at(ack_log, 0)), 32'd3);
        chk("A_ack_count", 32'(ack_log.size()), 32'd1);

        run_round(1'b0, 1'b1, 16'h0, 32'h0, 1'b1, 16'h0010, 32'h0);
        repeat (3) step();
        chk("B_rdata_hold", host_rdata, 32'hDEADBEEF);

        run_round(1'b0, 1'b1, 16'h0, 32'h0, 1'b0, 16'h0020, 32'h12345678);
        chk("W_rwn", 32'(mem_rwn), 32'h0);
        chk("W_wdata", mem_data_in, 32'h12345678);
        chk("W_rdata_kept", host_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) run_round(1'b1, 1'b0, 16'(i), $urandom, 1'b0, 16'h0, 32'h0);

        do_reset();
        rel_reset();
        run_round(1'b1, 1'b1, 16'(3), $urandom, 1'b1, 16'(5), 32'h0);
        run_round(1'b1, 1'b1, 16'(5), $urandom, 1'b1, 16'(3), 32'h0);
        chk("RR_ack0", 32'(log_at(ack_log, 0)), 32'd3);
        chk("RR_ack1", 32'(log_at(ack_log, 1)), 32'd7);
        chk("RR_ack2", 32'(log_at(ack_log, 2)), 32'd11);
        chk("RR_ack3", 32'(log_at(ack_log, 3)), 32'd15);
        chk("RR_order", 32'({log_at(grant_log, 0) == 0, log_at(grant_log, 1) == 1,
                             log_at(grant_log, 2) == 0, log_at(grant_log, 3) == 1}), 32'hF);

        step();
        push_txn(1'b1, 1'b1, 16'(3), 32'h0, 1'b0);
        host_req = 1'b1; host_rwn = 1'b1; host_address = 16'(3);
        found = 1'b0;
        for (int b = 0; b < 10 && !found; b++) begin
            step();
            if (mem_start) found = 1'b1;
        end
        chk("C_start_seen", 32'(found), 32'h1);
        step();
        chk("C_in_wait", 32'({busy, mem_start, host_ack}), 32'h4);
        reset = 1'b0;
        host_req = 1'b0;
        model_last = 1'b1;
        model_rdata = '0;
        #1;
        chk_zero("C_async");
        repeat (3) step();
        chk_zero("C_held");
        rel_reset();
        run_round(1'b1, 1'b1, 16'(2), $urandom, 1'b1, 16'(6), 32'h0);
        chk("C_first_grant", 32'(log_at(grant_log, 0)), 32'h0);
        chk("C_ack_count", 32'(ack_log.size()), 32'd2);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(1, 3);
            run_round(r[0], r[1], 16'($urandom_range(0, 7)), $urandom, 1'($urandom),
                      16'($urandom_range(0, 7)), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();
        chk("drain_start", 32'(exp_mem.size()), 32'h0);
        chk("drain_ack", 32'(exp_ack.size()), 32'h0);

        step();
        q_reset = 1'b1;
        q_host_req = 1'b1;
        q_host_rwn = 1'b1;
        q_host_address = 16'h0030;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            chk("L4_busy", 32'(q_busy), 32'(k >= 1 && k <= 6));
            chk("L4_start", 32'(q_mem_start), 32'(k == 1));
            chk("L4_ack", 32'(q_host_ack), 32'(k == 6));
            if (q_host_ack) q_host_req = 1'b0;
            q_mem_data_out = (k == 5) ? 32'hCAFEF00D : (32'h0BAD0000 | 32'(k));
        end
        chk("L4_rdata", q_host_rdata, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
